// File: rtl/wr_ingress_ctrl.sv
// rtl/wr_ingress_ctrl.sv - FIFO write-side ingress: 2-entry skid buffer, write strobe, fill level (WR_STALL_CNT_EN adds stall_cnt)
module wr_ingress_ctrl #(
    parameter int ADDR_SIZE    = 12,
    parameter int DATA_SIZE    = 8,
    parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 4
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 s_ready,
    output logic                 winc,
    output logic [DATA_SIZE-1:0] wdata,
    input  logic                 wFull,
    input  logic [ADDR_SIZE:0]   wptr,
    input  logic [ADDR_SIZE:0]   rptr_s,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 wAlmostFull
`ifdef WR_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [1:0]           occ, occ_next;
    logic [DATA_SIZE-1:0] buf0, buf1, buf0_next, buf1_next;
    logic                 push;
    logic [PW-1:0]        level_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign push  = s_valid & s_ready;
    assign winc  = (occ != 2'd0) & ~wFull;
    assign wdata = buf0;

    // buf0 always holds the oldest word; a pop shifts buf1 down before any push lands
    always_comb begin
        occ_next  = occ;
        buf0_next = buf0;
        buf1_next = buf1;
        if (winc) begin
            buf0_next = buf1;
            buf1_next = '0;
            occ_next  = occ - 2'd1;
        end
        if (push) begin
            if (occ_next == 2'd0) begin
                buf0_next = s_data;
            end else begin
                buf1_next = s_data;
            end
            occ_next = occ_next + 2'd1;
        end
    end

    assign level_next = gray2bin(wptr) - gray2bin(rptr_s);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            occ         <= 2'd0;
            buf0        <= '0;
            buf1        <= '0;
            s_ready     <= 1'b0;
            wlevel      <= '0;
            wAlmostFull <= 1'b0;
        end else begin
            occ         <= occ_next;
            buf0        <= buf0_next;
            buf1        <= buf1_next;
            s_ready     <= (occ_next < 2'd2);
            wlevel      <= level_next;
            wAlmostFull <= (level_next >= AFULL_LVL);
        end
    end

`ifdef WR_STALL_CNT_EN
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            stall_cnt <= 16'h0000;
        end else if (s_valid && !s_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// tb/tb_wr_ingress_ctrl.sv - bench for wr_ingress_ctrl with a FIFO pointer handler, memory and read side around it
module tb_wr_ingress_ctrl;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, winc, wFull, wAlmostFull;
    logic [7:0] wdata;
    logic [3:0] wptr, rptr_s, wlevel;
`ifdef WR_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    wr_ingress_ctrl #(.ADDR_SIZE(3), .DATA_SIZE(8), .AFULL_THRESH(6)) dut (
        .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .winc(winc), .wdata(wdata), .wFull(wFull), .wptr(wptr), .rptr_s(rptr_s),
        .wlevel(wlevel), .wAlmostFull(wAlmostFull)
`ifdef WR_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // FIFO around the DUT: binary counters, memory, 2-stage read-pointer sync
    logic [3:0] wbin, rbin, rb_s1, rb_s2;
    logic [7:0] mem [8];
    logic       rd_req = 1'b0;
    logic [7:0] exp_rd[$];
    int         n_rd = 0;
    int         last_rd = -1;

    assign wptr   = wbin ^ (wbin >> 1);
    assign rptr_s = rb_s2 ^ (rb_s2 >> 1);

    always @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wbin <= 4'd0; rbin <= 4'd0; rb_s1 <= 4'd0; rb_s2 <= 4'd0; wFull <= 1'b0;
        end else begin
            if (winc) begin
                mem[wbin[2:0]] <= wdata;
                wbin <= wbin + 4'd1;
            end
            wFull <= ((wbin + {3'd0, winc}) - rb_s2) == 4'd8;
            rb_s1 <= rbin;
            rb_s2 <= rb_s1;
            if (rd_req && rbin != wbin) begin
                rbin <= rbin + 4'd1;
                n_rd++;
                last_rd = int'(mem[rbin[2:0]]);
                if (exp_rd.size() == 0) chk("rd_unexpected", int'(mem[rbin[2:0]]), -1);
                else chk("rd_data", int'(mem[rbin[2:0]]), int'(exp_rd.pop_front()));
            end
        end
    end

    // Behavioural model: queue of accepted-but-unwritten words, level from binary pointers
    logic [7:0] q[$];
    int         edges_live = 0;
    logic [3:0] prev_lvl;
    bit         prev_ok = 0;
    int         n_winc = 0;
    int         last_wdata = -1;

    always @(posedge wclk) edges_live <= wrst ? edges_live + 1 : 0;

    always @(negedge wclk) begin
        bit rdy_m, pop_m;
        if (!wrst) begin
            q.delete();
            exp_rd.delete();
            prev_ok = 0;
        end else begin
            if (edges_live >= 1) begin
                rdy_m = q.size() < 2;
                pop_m = (q.size() != 0) && !wFull;
                chk("s_ready", int'(s_ready), int'(rdy_m));
                chk("winc", int'(winc), int'(pop_m));
                chk("winc_while_full", int'(winc && wFull), 0);
                if (pop_m) chk("wdata", int'(wdata), int'(q[0]));
                if (winc) begin
                    n_winc++;
                    last_wdata = int'(wdata);
                end
                if (pop_m) void'(q.pop_front());
                if (s_valid && rdy_m) begin
                    q.push_back(s_data);
                    exp_rd.push_back(s_data);
                end
            end
            if (prev_ok) begin
                chk("wlevel", int'(wlevel), int'(prev_lvl));
                chk("wAlmostFull", int'(wAlmostFull), int'(prev_lvl >= 4'd6));
                chk("wlevel_max", int'(wlevel <= 4'd8), 1);
            end
            prev_lvl = wbin - rb_s2;
            prev_ok  = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic do_reset();
        wrst = 1'b0; s_valid = 1'b0; rd_req = 1'b0;
        tick(3);
        wrst = 1'b1;
        tick(1);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        s_data = d; s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        tick(1);
    endtask

    task automatic read_one();
        int n = 0;
        while (rbin == wbin && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("read_timeout", n, 0);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    initial begin
        #3 wrst = 1'b0;
        tick(2);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_winc", int'(winc), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_wlevel", int'(wlevel), 0);
        chk("rst_wafull", int'(wAlmostFull), 0);
        wrst = 1'b1;
        chk("s_ready_before_edge", int'(s_ready), 0);
        tick(1);
        chk("s_ready_first_edge", int'(s_ready), 1);

        // ten back-to-back words, nothing read: 8 reach memory, 2 stay buffered
        n_winc = 0;
        for (int d = 1; d <= 10; d++) send(8'(d));
        s_valid = 1'b0;
        tick(5);
        chk("fill_winc_count", n_winc, 8);
        chk("fill_wFull", int'(wFull), 1);
        chk("fill_s_ready", int'(s_ready), 0);
        chk("fill_wlevel", int'(wlevel), 8);
        chk("fill_wafull", int'(wAlmostFull), 1);

        // one read frees one slot: exactly the older buffered word goes out
        n_winc = 0;
        read_one();
        tick(8);
        chk("one_read_winc", n_winc, 1);
        chk("one_read_wdata", last_wdata, 9);
        chk("one_read_s_ready", int'(s_ready), 1);
        n_rd = 0;
        for (int i = 0; i < 9; i++) read_one();
        chk("drain_count", n_rd, 9);
        chk("drain_last", last_rd, 10);

        // almost-full threshold
        do_reset();
        for (int d = 0; d < 6; d++) send(8'h20 + 8'(d));
        s_valid = 1'b0;
        tick(5);
        chk("af_wlevel6", int'(wlevel), 6);
        chk("af_set", int'(wAlmostFull), 1);
        read_one();
        tick(5);
        chk("af_wlevel5", int'(wlevel), 5);
        chk("af_clear", int'(wAlmostFull), 0);
        for (int i = 0; i < 5; i++) read_one();

        // 20 words through the FIFO across pointer wrap
        do_reset();
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            send(8'(i));
            s_valid = 1'b0;
            if (i >= 3) read_one();
        end
        for (int i = 0; i < 40 && n_rd < 20; i++) read_one();
        chk("wrap_read_count", n_rd, 20);
        chk("wrap_last", last_rd, 19);

        // asynchronous reset with two words buffered
        do_reset();
        for (int d = 1; d <= 10; d++) send(8'h40 + 8'(d));
        s_valid = 1'b0;
        tick(3);
        chk("pre_rst_s_ready", int'(s_ready), 0);
        #2 wrst = 1'b0;
        #1;
        chk("async_rst_winc", int'(winc), 0);
        chk("async_rst_s_ready", int'(s_ready), 0);
        chk("async_rst_wdata", int'(wdata), 0);
        chk("async_rst_wlevel", int'(wlevel), 0);
        @(posedge wclk);
        #1;
        tick(1);
        wrst = 1'b1;
        n_winc = 0;
        tick(10);
        chk("post_rst_no_stale", n_winc, 0);
        chk("post_rst_wlevel", int'(wlevel), 0);
        chk("post_rst_s_ready", int'(s_ready), 1);

`ifdef WR_STALL_CNT_EN
        do_reset();
        for (int d = 1; d <= 10; d++) send(8'(d));
        s_valid = 1'b0;
        tick(1);
        chk("stall_cnt_zero", int'(stall_cnt), 0);
        s_data = 8'hEE; s_valid = 1'b1;
        tick(5);
        s_valid = 1'b0;
        chk("stall_cnt_five", int'(stall_cnt), 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
